// File: rtl/ahb_apb_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_apb_bridge_if
//  Brief    : AHB-lite target and APB4 requester signal bundle for the
//             AHB-to-APB bridge. The slave modport is the bridge view; the
//             master modport is the view of the surrounding system.
//  Revision : 1.0  initial release
// ============================================================================
interface ahb_apb_bridge_if #(
    parameter int PADDR_WIDTH = 16
);
    // AHB-lite side
    logic                   HSEL;
    logic [31:0]            HADDR;
    logic [1:0]             HTRANS;
    logic                   HWRITE;
    logic [2:0]             HSIZE;
    logic [2:0]             HBURST;
    logic [3:0]             HPROT;
    logic [31:0]            HWDATA;
    logic [31:0]            HRDATA;
    logic                   HREADY;
    logic [1:0]             HRESP;

    // APB4 side
    logic [PADDR_WIDTH-1:0] PADDR;
    logic                   PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [31:0]            PWDATA;
    logic [3:0]             PSTRB;
    logic [2:0]             PPROT;
    logic [31:0]            PRDATA;
    logic                   PREADY;
    logic                   PSLVERR;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/ahb_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_apb_bridge
//  Brief    : AHB-lite subordinate converting every accepted AHB transfer
//             (each burst beat included) into one APB4 setup/access pair.
//             Misaligned or oversized transfers get a two-cycle ERROR
//             response without touching APB.
//  Revision : 1.0  initial release
// ============================================================================
module ahb_apb_bridge #(
    parameter int   PADDR_WIDTH  = 16,
    parameter logic PPROT_NONSEC = 1'b1
) (
    input  wire logic        HCLK,
    input  wire logic        HRESETn,
    ahb_apb_bridge_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_DONE   = 3'd4,
        S_ERR1   = 3'd5,
        S_ERR2   = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // Address-phase capture
    logic [PADDR_WIDTH-1:0] r_addr_ph;
    logic                   r_write_ph;
    logic [1:0]             r_size_ph;
    logic [1:0]             r_prot_ph;

    // Registered outputs
    logic [31:0]            r_hrdata;
    logic [PADDR_WIDTH-1:0] r_paddr;
    logic                   r_pwrite;
    logic [31:0]            r_pwdata;
    logic [3:0]             r_pstrb;
    logic [2:0]             r_pprot;

    // Combinational controls
    logic                   w_hready;
    logic [1:0]             w_hresp;
    logic                   w_psel;
    logic                   w_penable;
    logic                   w_accept;
    logic                   w_legal;
    logic [3:0]             w_strb;
    logic                   w_unused_ok;

    // Only NONSEQ/SEQ are real transfers; HREADY gates acceptance.
    assign w_accept = bus.HSEL & bus.HTRANS[1] & w_hready;

    // Alignment / size legality of the live address phase
    assign w_legal = (bus.HSIZE == 3'd0) ||
                     ((bus.HSIZE == 3'd1) && !bus.HADDR[0]) ||
                     ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] == 2'b00));

    // Burst type, BUSY/SEQ distinction and upper address/prot bits carry no meaning here
    assign w_unused_ok = ^{bus.HBURST, bus.HTRANS[0], bus.HADDR, bus.HPROT[3:2]};

    // Byte-lane strobes derived from the registered size and low address bits
    always_comb begin
        w_strb = 4'b0000;
        case (r_size_ph)
            2'd0:    w_strb = 4'b0001 << r_addr_ph[1:0];
            2'd1:    w_strb = r_addr_ph[1] ? 4'b1100 : 4'b0011;
            default: w_strb = 4'b1111;
        endcase
    end

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_hready    = 1'b1;
        w_hresp     = 2'b00;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (r_state == S_ERR2) begin
                    w_hresp = 2'b01;
                end
                if (w_accept) begin
                    w_state_nxt = w_legal ? S_LATCH : S_ERR1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LATCH: begin
                w_hready    = 1'b0;
                w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                w_hready    = 1'b0;
                w_psel      = 1'b1;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                w_hready  = 1'b0;
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (bus.PREADY) begin
                    w_state_nxt = bus.PSLVERR ? S_ERR1 : S_DONE;
                end
            end
            S_ERR1: begin
                w_hready    = 1'b0;
                w_hresp     = 2'b01;
                w_state_nxt = S_ERR2;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the AHB address phase whenever a transfer is accepted
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr_ph  <= '0;
            r_write_ph <= 1'b0;
            r_size_ph  <= 2'd0;
            r_prot_ph  <= 2'd0;
        end else if (w_accept) begin
            r_addr_ph  <= bus.HADDR[PADDR_WIDTH-1:0];
            r_write_ph <= bus.HWRITE;
            r_size_ph  <= bus.HSIZE[1:0];
            r_prot_ph  <= bus.HPROT[1:0];
        end
    end

    // APB request fields load in LATCH and hold until the next transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= 32'd0;
            r_pstrb  <= 4'b0000;
            r_pprot  <= 3'b000;
        end else if (r_state == S_LATCH) begin
            r_paddr  <= r_addr_ph;
            r_pwrite <= r_write_ph;
            r_pstrb  <= r_write_ph ? w_strb : 4'b0000;
            r_pprot  <= {~r_prot_ph[0], PPROT_NONSEC, r_prot_ph[1]};
            if (r_write_ph) begin
                r_pwdata <= bus.HWDATA;
            end
        end
    end

    // Read data is captured only on an error-free read completion
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hrdata <= 32'd0;
        end else if ((r_state == S_ACCESS) && bus.PREADY && !bus.PSLVERR && !r_pwrite) begin
            r_hrdata <= bus.PRDATA;
        end
    end

    assign bus.HRDATA  = r_hrdata;
    assign bus.HREADY  = w_hready;
    assign bus.HRESP   = w_hresp;
    assign bus.PADDR   = r_paddr;
    assign bus.PSEL    = w_psel;
    assign bus.PENABLE = w_penable;
    assign bus.PWRITE  = r_pwrite;
    assign bus.PWDATA  = r_pwdata;
    assign bus.PSTRB   = r_pstrb;
    assign bus.PPROT   = r_pprot;

endmodule
`default_nettype wire

// File: tb/tb_ahb_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_apb_bridge
//  Brief    : Directed self-checking bench for ahb_apb_bridge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_apb_bridge;

    logic HCLK;
    logic HRESETn;
    int   n_cmp = 0;
    int   n_err = 0;

    ahb_apb_bridge_if #(.PADDR_WIDTH(16)) bus ();

    ahb_apb_bridge #(
        .PADDR_WIDTH  (16),
        .PPROT_NONSEC (1'b1)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    // Present an address phase and let the next edge accept it
    task automatic addr_phase(input logic [31:0] addr, input logic wr,
                              input logic [2:0] size, input logic [3:0] prot);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HPROT  = prot;
        tick();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
    endtask

    task automatic test_reset;
        HRESETn = 1'b0;
        #1;
        n_cmp++; if (bus.HREADY !== 1'b1) begin n_err++; $display("FAIL rst_hready: got %b want 1", bus.HREADY); end
        n_cmp++; if (bus.HRESP !== 2'b00) begin n_err++; $display("FAIL rst_hresp: got %b want 00", bus.HRESP); end
        n_cmp++; if (bus.HRDATA !== 32'd0) begin n_err++; $display("FAIL rst_hrdata: got %h want 0", bus.HRDATA); end
        n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin n_err++; $display("FAIL rst_pctl: got %b want 000", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
        n_cmp++; if (bus.PADDR !== 16'd0) begin n_err++; $display("FAIL rst_paddr: got %h want 0", bus.PADDR); end
        n_cmp++; if (bus.PWDATA !== 32'd0) begin n_err++; $display("FAIL rst_pwdata: got %h want 0", bus.PWDATA); end
        n_cmp++; if ({bus.PSTRB, bus.PPROT} !== 7'd0) begin n_err++; $display("FAIL rst_pstrb_pprot: got %b want 0", {bus.PSTRB, bus.PPROT}); end
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_not_accepted;
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b01;
        bus.HADDR  = 32'h0000_0100;
        bus.HWRITE = 1'b1;
        tick();
        n_cmp++; if ({bus.HREADY, bus.PSEL} !== 2'b10) begin n_err++; $display("FAIL busy_ignored: got %b want 10", {bus.HREADY, bus.PSEL}); end
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b10;
        tick();
        tick();
        n_cmp++; if ({bus.HREADY, bus.PSEL} !== 2'b10) begin n_err++; $display("FAIL unsel_ignored: got %b want 10", {bus.HREADY, bus.PSEL}); end
        bus.HTRANS = 2'b00;
    endtask

    task automatic test_write;
        bus.PREADY = 1'b1;
        addr_phase(32'h0000_1004, 1'b1, 3'd2, 4'b0011);
        bus.HWDATA = 32'hDEAD_BEEF;
        // LATCH (N+1)
        n_cmp++; if ({bus.HREADY, bus.PSEL} !== 2'b00) begin n_err++; $display("FAIL wr_latch: got %b want 00", {bus.HREADY, bus.PSEL}); end
        tick();
        // SETUP (N+2)
        n_cmp++; if ({bus.HREADY, bus.PSEL, bus.PENABLE} !== 3'b010) begin n_err++; $display("FAIL wr_setup_ctl: got %b want 010", {bus.HREADY, bus.PSEL, bus.PENABLE}); end
        n_cmp++; if (bus.PADDR !== 16'h1004) begin n_err++; $display("FAIL wr_paddr: got %h want 1004", bus.PADDR); end
        n_cmp++; if (bus.PSTRB !== 4'b1111) begin n_err++; $display("FAIL wr_pstrb: got %b want 1111", bus.PSTRB); end
        n_cmp++; if (bus.PWDATA !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_pwdata: got %h want deadbeef", bus.PWDATA); end
        n_cmp++; if (bus.PWRITE !== 1'b1) begin n_err++; $display("FAIL wr_pwrite: got %b want 1", bus.PWRITE); end
        n_cmp++; if (bus.PPROT !== 3'b011) begin n_err++; $display("FAIL wr_pprot: got %b want 011", bus.PPROT); end
        tick();
        // ACCESS (N+3)
        n_cmp++; if ({bus.HREADY, bus.PSEL, bus.PENABLE} !== 3'b011) begin n_err++; $display("FAIL wr_access_ctl: got %b want 011", {bus.HREADY, bus.PSEL, bus.PENABLE}); end
        tick();
        // DONE (N+4)
        n_cmp++; if ({bus.HREADY, bus.HRESP, bus.PSEL, bus.PENABLE} !== 5'b10000) begin n_err++; $display("FAIL wr_done: got %b want 10000", {bus.HREADY, bus.HRESP, bus.PSEL, bus.PENABLE}); end
        tick();
    endtask

    task automatic test_read_wait;
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hBAD0_BAD0;
        addr_phase(32'h0000_2008, 1'b0, 3'd2, 4'b0000);
        tick();
        // SETUP (N+2)
        n_cmp++; if ({bus.PSTRB, bus.PWRITE} !== 5'b00000) begin n_err++; $display("FAIL rd_pstrb_pwrite: got %b want 00000", {bus.PSTRB, bus.PWRITE}); end
        n_cmp++; if (bus.PADDR !== 16'h2008) begin n_err++; $display("FAIL rd_paddr: got %h want 2008", bus.PADDR); end
        n_cmp++; if (bus.PPROT !== 3'b110) begin n_err++; $display("FAIL rd_pprot: got %b want 110", bus.PPROT); end
        n_cmp++; if (bus.PWDATA !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_pwdata_hold: got %h want deadbeef", bus.PWDATA); end
        tick();
        tick();
        // ACCESS second wait cycle (N+4)
        n_cmp++; if ({bus.HREADY, bus.PSEL, bus.PENABLE} !== 3'b011) begin n_err++; $display("FAIL rd_wait_ctl: got %b want 011", {bus.HREADY, bus.PSEL, bus.PENABLE}); end
        tick();
        // ACCESS completing (N+5)
        n_cmp++; if (bus.HRDATA !== 32'd0) begin n_err++; $display("FAIL rd_early_capture: got %h want 0", bus.HRDATA); end
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h1234_5678;
        tick();
        // DONE (N+6)
        n_cmp++; if ({bus.HREADY, bus.HRESP, bus.PSEL} !== 4'b1000) begin n_err++; $display("FAIL rd_done_ctl: got %b want 1000", {bus.HREADY, bus.HRESP, bus.PSEL}); end
        n_cmp++; if (bus.HRDATA !== 32'h1234_5678) begin n_err++; $display("FAIL rd_hrdata: got %h want 12345678", bus.HRDATA); end
        tick();
    endtask

    task automatic test_slverr;
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hFFFF_0000;
        addr_phase(32'h0000_3000, 1'b1, 3'd2, 4'b0010);
        bus.HWDATA = 32'h1111_1111;
        tick();
        tick();
        tick();
        bus.PSLVERR = 1'b0;
        // ERR1
        n_cmp++; if ({bus.HREADY, bus.HRESP, bus.PSEL} !== 4'b0010) begin n_err++; $display("FAIL slv_err1: got %b want 0010", {bus.HREADY, bus.HRESP, bus.PSEL}); end
        tick();
        // ERR2
        n_cmp++; if ({bus.HREADY, bus.HRESP} !== 3'b101) begin n_err++; $display("FAIL slv_err2: got %b want 101", {bus.HREADY, bus.HRESP}); end
        tick();
        n_cmp++; if ({bus.HREADY, bus.HRESP} !== 3'b100) begin n_err++; $display("FAIL slv_idle: got %b want 100", {bus.HREADY, bus.HRESP}); end
        n_cmp++; if (bus.HRDATA !== 32'h1234_5678) begin n_err++; $display("FAIL slv_hrdata_hold: got %h want 12345678", bus.HRDATA); end
    endtask

    task automatic test_strobe_illegal;
        bus.PREADY = 1'b1;
        addr_phase(32'h0000_4002, 1'b1, 3'd0, 4'b0000);
        bus.HWDATA = 32'h00AB_0000;
        tick();
        n_cmp++; if (bus.PSTRB !== 4'b0100) begin n_err++; $display("FAIL byte_pstrb: got %b want 0100", bus.PSTRB); end
        tick();
        tick();
        addr_phase(32'h0000_4002, 1'b1, 3'd1, 4'b0000);
        tick();
        n_cmp++; if (bus.PSTRB !== 4'b1100) begin n_err++; $display("FAIL half_pstrb: got %b want 1100", bus.PSTRB); end
        tick();
        tick();
        addr_phase(32'h0000_4006, 1'b1, 3'd2, 4'b0000);
        // ERR1
        n_cmp++; if ({bus.HREADY, bus.HRESP, bus.PSEL} !== 4'b0010) begin n_err++; $display("FAIL ill_err1: got %b want 0010", {bus.HREADY, bus.HRESP, bus.PSEL}); end
        tick();
        // ERR2
        n_cmp++; if ({bus.HREADY, bus.HRESP, bus.PSEL} !== 4'b1010) begin n_err++; $display("FAIL ill_err2: got %b want 1010", {bus.HREADY, bus.HRESP, bus.PSEL}); end
        tick();
        n_cmp++; if ({bus.HREADY, bus.PSEL, bus.PADDR} !== {2'b10, 16'h4002}) begin n_err++; $display("FAIL ill_no_apb: got %h want 24002", {bus.HREADY, bus.PSEL, bus.PADDR}); end
    endtask

    // INCR4 write burst; rst_beat >= 0 asserts reset in that beat's ACCESS
    task automatic run_burst(input int rst_beat);
        logic [15:0] exp_a;
        logic [31:0] exp_d;
        bus.PREADY = 1'b1;
        bus.HBURST = 3'b011;
        addr_phase(32'h0000_5000, 1'b1, 3'd2, 4'b0000);
        for (int b = 0; b < 4; b++) begin
            exp_a      = 16'h5000 + 16'(b * 4);
            exp_d      = 32'hA5A5_0000 + 32'(b);
            bus.HWDATA = exp_d;
            if (b < 3) begin
                bus.HSEL   = 1'b1;
                bus.HTRANS = 2'b11;
                bus.HADDR  = 32'h0000_5000 + 32'((b + 1) * 4);
            end else begin
                bus.HSEL   = 1'b0;
                bus.HTRANS = 2'b00;
            end
            tick();
            n_cmp++; if ({bus.PSEL, bus.PADDR} !== {1'b1, exp_a}) begin n_err++; $display("FAIL burst_paddr[%0d]: got %h want %h", b, {bus.PSEL, bus.PADDR}, {1'b1, exp_a}); end
            n_cmp++; if (bus.PWDATA !== exp_d) begin n_err++; $display("FAIL burst_pwdata[%0d]: got %h want %h", b, bus.PWDATA, exp_d); end
            tick();
            if (b == rst_beat) begin
                HRESETn = 1'b0;
                #1;
                n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.HREADY, bus.HRESP} !== 5'b00100) begin n_err++; $display("FAIL midrst_ctl: got %b want 00100", {bus.PSEL, bus.PENABLE, bus.HREADY, bus.HRESP}); end
                n_cmp++; if ({bus.PADDR, bus.PWDATA} !== 48'd0) begin n_err++; $display("FAIL midrst_data: got %h want 0", {bus.PADDR, bus.PWDATA}); end
                bus.HSEL   = 1'b0;
                bus.HTRANS = 2'b00;
                tick();
                HRESETn = 1'b1;
                tick();
                tick();
                n_cmp++; if ({bus.HREADY, bus.PSEL, bus.PENABLE} !== 3'b100) begin n_err++; $display("FAIL midrst_idle: got %b want 100", {bus.HREADY, bus.PSEL, bus.PENABLE}); end
                return;
            end
            tick();
            n_cmp++; if ({bus.HREADY, bus.HRESP, bus.PSEL} !== 4'b1000) begin n_err++; $display("FAIL burst_done[%0d]: got %b want 1000", b, {bus.HREADY, bus.HRESP, bus.PSEL}); end
            tick();
        end
        n_cmp++; if ({bus.HREADY, bus.PSEL} !== 2'b10) begin n_err++; $display("FAIL burst_end_idle: got %b want 10", {bus.HREADY, bus.PSEL}); end
    endtask

    task automatic test_back_to_back;
        run_burst(-1);
    endtask

    task automatic test_reset_mid_burst;
        run_burst(1);
    endtask

    initial begin
        HRESETn     = 1'b0;
        bus.HSEL    = 1'b0;
        bus.HADDR   = 32'd0;
        bus.HTRANS  = 2'b00;
        bus.HWRITE  = 1'b0;
        bus.HSIZE   = 3'd0;
        bus.HBURST  = 3'd0;
        bus.HPROT   = 4'd0;
        bus.HWDATA  = 32'd0;
        bus.PRDATA  = 32'd0;
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b0;
        tick();
        test_reset();
        test_not_accepted();
        test_write();
        test_read_wait();
        test_slverr();
        test_strobe_illegal();
        test_back_to_back();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
